// File: rtl/lives_manager.sv
// Player life-count controller feeding the HUD lives display.
// Sequences death pause, respawn pulse, post-respawn grace window and game-over.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | after reset, waiting for newGame; play frozen
// PLAY      | ball in play; losses and 1-ups update the count
// DYING     | frame-counted death pause; play frozen, 1-ups still count
// GAME_OVER | no lives left; only newGame leaves
module lives_manager #(
    parameter int INIT_LIVES    = 3,
    parameter int MAX_LIVES     = 9,
    parameter int DEATH_FRAMES  = 60,
    parameter int INVULN_FRAMES = 120
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       newGame,
    input  logic       ballLost,
    input  logic       extraLife,
    output logic [3:0] lives,
    output logic       gameOver,
    output logic       freezePlay,
    output logic       respawn,
    output logic       invulnerable
);

    localparam logic [3:0] INIT4  = 4'(INIT_LIVES);
    localparam logic [3:0] MAX4   = 4'(MAX_LIVES);
    localparam logic [4:0] MAX5   = 5'(MAX_LIVES);
    localparam logic [7:0] DEATH8 = 8'(DEATH_FRAMES);
    localparam logic [7:0] INV8   = 8'(INVULN_FRAMES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        DYING     = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] lives_nxt;
    logic [7:0] death_cnt, death_cnt_nxt;
    logic [7:0] invuln_cnt, invuln_cnt_nxt;
    logic       respawn_nxt;

    logic       loss;
    logic [4:0] play_sum;
    logic [3:0] play_sat;
    logic [4:0] inc_sum;
    logic [3:0] inc_sat;

    // Loss is gated by the pre-edge grace counter, so a frame tick on the
    // same cycle cannot open or close the window for that loss.
    always_comb begin
        loss     = ballLost && (invuln_cnt == 8'd0);
        play_sum = {1'b0, lives} + {4'b0, extraLife} - {4'b0, loss};
        play_sat = (play_sum > MAX5) ? MAX4 : play_sum[3:0];
        inc_sum  = {1'b0, lives} + {4'b0, extraLife};
        inc_sat  = (inc_sum > MAX5) ? MAX4 : inc_sum[3:0];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            lives      <= INIT4;
            death_cnt  <= 8'd0;
            invuln_cnt <= 8'd0;
            respawn    <= 1'b0;
        end else begin
            state      <= state_nxt;
            lives      <= lives_nxt;
            death_cnt  <= death_cnt_nxt;
            invuln_cnt <= invuln_cnt_nxt;
            respawn    <= respawn_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        lives_nxt      = lives;
        death_cnt_nxt  = death_cnt;
        invuln_cnt_nxt = invuln_cnt;
        respawn_nxt    = 1'b0;

        if (newGame) begin
            state_nxt      = PLAY;
            lives_nxt      = INIT4;
            death_cnt_nxt  = 8'd0;
            invuln_cnt_nxt = INV8;
            respawn_nxt    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    lives_nxt = INIT4;
                end
                PLAY: begin
                    if (loss) begin
                        if (play_sat == 4'd0) begin
                            state_nxt = GAME_OVER;
                            lives_nxt = 4'd0;
                        end else begin
                            state_nxt     = DYING;
                            lives_nxt     = play_sat;
                            death_cnt_nxt = DEATH8;
                        end
                    end else begin
                        lives_nxt = play_sat;
                        if (startOfFrame && (invuln_cnt != 8'd0))
                            invuln_cnt_nxt = invuln_cnt - 8'd1;
                    end
                end
                DYING: begin
                    lives_nxt = inc_sat;
                    if (startOfFrame) begin
                        death_cnt_nxt = death_cnt - 8'd1;
                        if (death_cnt == 8'd1) begin
                            state_nxt      = PLAY;
                            invuln_cnt_nxt = INV8;
                            respawn_nxt    = 1'b1;
                        end
                    end
                end
                GAME_OVER: begin
                    lives_nxt = 4'd0;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign gameOver     = (state == GAME_OVER);
    assign freezePlay   = (state != PLAY);
    assign invulnerable = (invuln_cnt != 8'd0);

endmodule
